// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcode/funct
// encodings, ALU operation codes and the control word carried through the
// DEC->EXE->MEM->WB stage registers.
package mips_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    memwrite;
    logic    branch;
    logic    bne;
    logic    alusrc;
    logic    regdst;
    alu_op_e alucontrol;
    logic    valid;
  } ctrl_t;

  // All-zero word: no writes, no branch, not valid.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational main + ALU decoder for the DEC stage.
// Ports:
//   opcode  in   6  instr[31:26]
//   funct   in   6  instr[5:0]
//   ctrl    out     control word for the EXE stage register
//   jump    out  1  j decoded
//   extop   out  1  1 = sign-extend immediate
//   illegal out  1  unknown opcode or R-type funct
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ZEXT_LOGIC = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       jump,
  output logic       extop,
  output logic       illegal
);

  localparam logic LogicExtop = (ZEXT_LOGIC == 0);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    jump    = 1'b0;
    extop   = 1'b1;
    illegal = 1'b0;

    case (opcode)
      OpRtype: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.valid    = 1'b1;
        case (funct)
          FnAdd:   ctrl.alucontrol = AluAdd;
          FnSub:   ctrl.alucontrol = AluSub;
          FnAnd:   ctrl.alucontrol = AluAnd;
          FnOr:    ctrl.alucontrol = AluOr;
          FnSlt:   ctrl.alucontrol = AluSlt;
          default: illegal = 1'b1;
        endcase
      end
      OpLw: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = AluAdd;
        ctrl.valid      = 1'b1;
      end
      OpSw: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = AluAdd;
        ctrl.valid      = 1'b1;
      end
      OpBeq, OpBne: begin
        ctrl.branch     = 1'b1;
        ctrl.bne        = (opcode == OpBne);
        ctrl.alucontrol = AluSub;
        ctrl.valid      = 1'b1;
      end
      OpAddi, OpAndi, OpOri, OpSlti: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.valid    = 1'b1;
        case (opcode)
          OpAndi:  ctrl.alucontrol = AluAnd;
          OpOri:   ctrl.alucontrol = AluOr;
          OpSlti:  ctrl.alucontrol = AluSlt;
          default: ctrl.alucontrol = AluAdd;
        endcase
        if (opcode == OpAndi || opcode == OpOri) extop = LogicExtop;
      end
      OpJ: begin
        // Travels down the pipe as a valid no-op.
        jump       = 1'b1;
        ctrl.valid = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions must not write, branch or jump.
    if (illegal) begin
      ctrl = CTRL_BUBBLE;
      jump = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS core. Decodes in DEC and
// carries the control word through EXE, MEM and WB stage registers, with
// stall bubbles, wrong-path flush and branch resolution in EXE or MEM.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   stall                       bubble into EXE this edge
//   opcode, funct               DEC-stage instruction fields
//   zero_EXE, zero_MEM          ALU zero flag in EXE / MEM
//   jump_DEC, extop_DEC,
//   illegal_DEC                 combinational decode outputs
//   alusrc_EXE, regdst_EXE,
//   alucontrol_EXE,
//   memtoreg_EXE                EXE-stage controls
//   memwrite_MEM, regwrite_MEM  MEM-stage controls
//   pcsrc, flush_IFID           branch taken / IF-ID clear
//   regwrite_WB, memtoreg_WB,
//   valid_WB                    WB-stage controls
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W    = 3,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned ZEXT_LOGIC   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero_EXE,
  input  logic                 zero_MEM,
  output logic                 jump_DEC,
  output logic                 extop_DEC,
  output logic                 illegal_DEC,
  output logic                 alusrc_EXE,
  output logic                 regdst_EXE,
  output logic [ALUCTRL_W-1:0] alucontrol_EXE,
  output logic                 memtoreg_EXE,
  output logic                 memwrite_MEM,
  output logic                 regwrite_MEM,
  output logic                 pcsrc,
  output logic                 flush_IFID,
  output logic                 regwrite_WB,
  output logic                 memtoreg_WB,
  output logic                 valid_WB
);

  // Resolving in MEM means two younger instructions (EXE and DEC) are wrong-path.
  localparam logic FlushMem = (BRANCH_STAGE != 2);

  ctrl_t dec_ctrl;
  ctrl_t exe_d, exe_q;
  ctrl_t mem_d, mem_q;
  ctrl_t wb_q;
  logic  unused_zero;
  logic  unused_wb;

  ctrl_decoder #(
    .ZEXT_LOGIC(ZEXT_LOGIC)
  ) u_decoder (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .jump    (jump_DEC),
    .extop   (extop_DEC),
    .illegal (illegal_DEC)
  );

  generate
    if (BRANCH_STAGE == 2) begin : g_br_exe
      assign pcsrc       = exe_q.branch & (zero_EXE ^ exe_q.bne) & exe_q.valid;
      assign unused_zero = zero_MEM;
    end else begin : g_br_mem
      assign pcsrc       = mem_q.branch & (zero_MEM ^ mem_q.bne) & mem_q.valid;
      assign unused_zero = zero_EXE;
    end
  endgenerate

  always_comb begin
    exe_d = dec_ctrl;
    if (stall || pcsrc) exe_d = CTRL_BUBBLE;
    mem_d = exe_q;
    if (pcsrc && FlushMem) mem_d = CTRL_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_q <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  assign flush_IFID     = pcsrc | jump_DEC;
  assign alusrc_EXE     = exe_q.alusrc;
  assign regdst_EXE     = exe_q.regdst;
  assign alucontrol_EXE = ALUCTRL_W'(exe_q.alucontrol);
  assign memtoreg_EXE   = exe_q.memtoreg;
  assign memwrite_MEM   = mem_q.memwrite;
  assign regwrite_MEM   = mem_q.regwrite;
  assign regwrite_WB    = wb_q.regwrite;
  assign memtoreg_WB    = wb_q.memtoreg;
  assign valid_WB       = wb_q.valid;

  // WB only needs the write-back fields; the rest ride along for debug visibility.
  assign unused_wb = ^{wb_q.memwrite, wb_q.branch, wb_q.bne, wb_q.alusrc, wb_q.regdst,
                       wb_q.alucontrol};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. Two instances share stimulus:
// dut_a resolves branches in MEM, dut_b in EXE.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] NOP = 6'b111111;  // illegal opcode, travels as a bubble
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] RT  = 6'b000000;

  logic       clk = 1'b0;
  logic       reset, stall, zero_e, zero_m;
  logic [5:0] opcode, funct;

  logic       jump_a, extop_a, ill_a, alusrc_a, regdst_a, m2re_a, mw_a, rwm_a;
  logic       pcsrc_a, fl_a, rwwb_a, m2rwb_a, vwb_a;
  logic [2:0] aluc_a;
  logic       jump_b, extop_b, ill_b, alusrc_b, regdst_b, m2re_b, mw_b, rwm_b;
  logic       pcsrc_b, fl_b, rwwb_b, m2rwb_b, vwb_b;
  logic [2:0] aluc_b;

  pipe_ctrl_unit #(.ALUCTRL_W(3), .BRANCH_STAGE(3), .ZEXT_LOGIC(1)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
    .zero_EXE(zero_e), .zero_MEM(zero_m), .jump_DEC(jump_a), .extop_DEC(extop_a),
    .illegal_DEC(ill_a), .alusrc_EXE(alusrc_a), .regdst_EXE(regdst_a),
    .alucontrol_EXE(aluc_a), .memtoreg_EXE(m2re_a), .memwrite_MEM(mw_a),
    .regwrite_MEM(rwm_a), .pcsrc(pcsrc_a), .flush_IFID(fl_a), .regwrite_WB(rwwb_a),
    .memtoreg_WB(m2rwb_a), .valid_WB(vwb_a)
  );

  pipe_ctrl_unit #(.ALUCTRL_W(3), .BRANCH_STAGE(2), .ZEXT_LOGIC(1)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
    .zero_EXE(zero_e), .zero_MEM(zero_m), .jump_DEC(jump_b), .extop_DEC(extop_b),
    .illegal_DEC(ill_b), .alusrc_EXE(alusrc_b), .regdst_EXE(regdst_b),
    .alucontrol_EXE(aluc_b), .memtoreg_EXE(m2re_b), .memwrite_MEM(mw_b),
    .regwrite_MEM(rwm_b), .pcsrc(pcsrc_b), .flush_IFID(fl_b), .regwrite_WB(rwwb_b),
    .memtoreg_WB(m2rwb_b), .valid_WB(vwb_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    opcode = NOP;
    funct  = 6'b000000;
    stall  = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       jump;
    logic       extop;
    logic       ill;
    logic       alusrc;
    logic       regdst;
    logic [2:0] aluc;
    logic       m2r;
    logic       mw;
    logic       rw;
    logic       v;
  } vec_t;

  localparam int N = 15;
  vec_t tbl[N];

  // Branch sequence: beq then three sw's; beq taken when it reaches the resolving stage.
  task automatic br_seq(input bit st_c1, input bit st_c2, input bit use_a, input bit use_b,
                        input string tag);
    nop(4);
    zero_e = 1'b0;
    zero_m = 1'b0;
    opcode = BEQ;
    step();
    zero_e = 1'b1;
    opcode = SW;
    stall  = st_c1;
    #1;
    if (use_a) chk({tag, " a pcsrc c1"}, pcsrc_a, 0);
    if (use_b) chk({tag, " b pcsrc c1"}, pcsrc_b, 1);
    if (use_b) chk({tag, " b flush_IFID c1"}, fl_b, 1);
    step();
    zero_e = 1'b0;
    zero_m = 1'b1;
    stall  = st_c2;
    #1;
    if (use_a) chk({tag, " a pcsrc c2"}, pcsrc_a, 1);
    if (use_a) chk({tag, " a memwrite c2"}, mw_a, 0);
    if (use_b) chk({tag, " b pcsrc c2"}, pcsrc_b, 0);
    step();
    zero_m = 1'b0;
    stall  = 1'b0;
    #1;
    if (use_a) chk({tag, " a pcsrc c3"}, pcsrc_a, 0);
    if (use_a) chk({tag, " a memwrite c3"}, mw_a, 0);
    if (use_b) chk({tag, " b memwrite c3"}, mw_b, 0);
    step();
    opcode = NOP;
    if (use_a) chk({tag, " a memwrite c4"}, mw_a, 0);
    if (use_b) chk({tag, " b memwrite c4"}, mw_b, 1);
    step();
    if (use_a) chk({tag, " a memwrite c5"}, mw_a, 1);
    if (use_b) chk({tag, " b memwrite c5"}, mw_b, 1);
  endtask

  initial begin
    //            op         fn         j     ext   ill   as    rd    aluc    m2r   mw    rw    v
    tbl[0]  = '{RT,        6'b100000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{RT,        6'b100010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{RT,        6'b100100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{RT,        6'b100101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{RT,        6'b101010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{LW,        6'b111111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{SW,        6'b100000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{BEQ,       6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{6'b001000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{6'b001100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{6'b001101, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{6'b001010, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{6'b000010, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{NOP,       6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{RT,        6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles with lw presented.
    reset  = 1'b1;
    stall  = 1'b0;
    zero_e = 1'b0;
    zero_m = 1'b0;
    opcode = LW;
    funct  = 6'b000000;
    step();
    step();
    chk("rst alusrc_EXE", alusrc_a, 0);
    chk("rst memtoreg_EXE", m2re_a, 0);
    chk("rst alucontrol_EXE", aluc_a, 0);
    chk("rst memwrite_MEM", mw_a, 0);
    chk("rst regwrite_MEM", rwm_a, 0);
    chk("rst pcsrc", pcsrc_a, 0);
    chk("rst regwrite_WB", rwwb_a, 0);
    chk("rst memtoreg_WB", m2rwb_a, 0);
    chk("rst valid_WB", vwb_a, 0);
    chk("rst b valid_WB", vwb_b, 0);
    reset = 1'b0;
    step();
    chk("lw e1 memtoreg_EXE", m2re_a, 1);
    chk("lw e1 memtoreg_WB", m2rwb_a, 0);
    opcode = NOP;
    step();
    chk("lw e2 memtoreg_WB", m2rwb_a, 0);
    step();
    chk("lw e3 memtoreg_WB", m2rwb_a, 1);
    nop(3);

    // Table: one vector per cycle, each checked at DEC, EXE, MEM and WB.
    for (int i = 0; i < N + 3; i++) begin
      if (i < N) begin
        opcode = tbl[i].op;
        funct  = tbl[i].fn;
        #1;
        chk($sformatf("t%0d jump_DEC", i), jump_a, tbl[i].jump);
        chk($sformatf("t%0d flush_IFID", i), fl_a, tbl[i].jump);
        chk($sformatf("t%0d illegal_DEC", i), ill_a, tbl[i].ill);
        if (!tbl[i].ill) chk($sformatf("t%0d extop_DEC", i), extop_a, tbl[i].extop);
      end else begin
        opcode = NOP;
        funct  = 6'b000000;
      end
      step();
      chk($sformatf("t%0d pcsrc", i), pcsrc_a, 0);
      if (i < N) begin
        chk($sformatf("t%0d alusrc_EXE", i), alusrc_a, tbl[i].alusrc);
        chk($sformatf("t%0d regdst_EXE", i), regdst_a, tbl[i].regdst);
        chk($sformatf("t%0d alucontrol_EXE", i), aluc_a, tbl[i].aluc);
        chk($sformatf("t%0d memtoreg_EXE", i), m2re_a, tbl[i].m2r);
      end
      if (i >= 1 && i - 1 < N) begin
        chk($sformatf("t%0d memwrite_MEM", i - 1), mw_a, tbl[i-1].mw);
        chk($sformatf("t%0d regwrite_MEM", i - 1), rwm_a, tbl[i-1].rw);
      end
      if (i >= 2 && i - 2 < N) begin
        chk($sformatf("t%0d regwrite_WB", i - 2), rwwb_a, tbl[i-2].rw);
        chk($sformatf("t%0d memtoreg_WB", i - 2), m2rwb_a, tbl[i-2].m2r);
        chk($sformatf("t%0d valid_WB", i - 2), vwb_a, tbl[i-2].v);
      end
    end

    // Stall one cycle behind lw: bubble travels down, add arrives one cycle late.
    nop(3);
    opcode = LW;
    step();
    opcode = RT;
    funct  = 6'b100000;
    stall  = 1'b1;
    step();
    chk("stall bubble memtoreg_EXE", m2re_a, 0);
    chk("stall bubble regdst_EXE", regdst_a, 0);
    stall = 1'b0;
    step();
    chk("stall add regdst_EXE", regdst_a, 1);
    chk("stall bubble regwrite_MEM", rwm_a, 0);
    chk("stall lw memtoreg_WB", m2rwb_a, 1);
    opcode = NOP;
    step();
    chk("stall bubble valid_WB", vwb_a, 0);
    chk("stall bubble regwrite_WB", rwwb_a, 0);
    step();
    chk("stall add valid_WB", vwb_a, 1);
    chk("stall add regwrite_WB", rwwb_a, 1);

    // Taken beq, then same-cycle stall with pcsrc for each resolve stage.
    br_seq(1'b0, 1'b0, 1'b1, 1'b1, "flush");
    br_seq(1'b0, 1'b1, 1'b1, 1'b0, "stall+flush mem");
    br_seq(1'b1, 1'b0, 1'b0, 1'b1, "stall+flush exe");

    // bne: taken only when zero is clear.
    nop(4);
    opcode = BNE;
    step();
    opcode = NOP;
    zero_e = 1'b1;
    #1;
    chk("bne zero=1 b pcsrc", pcsrc_b, 0);
    zero_e = 1'b0;
    #1;
    chk("bne zero=0 b pcsrc", pcsrc_b, 1);
    step();
    zero_m = 1'b1;
    #1;
    chk("bne zero=1 a pcsrc", pcsrc_a, 0);
    zero_m = 1'b0;
    #1;
    chk("bne zero=0 a pcsrc", pcsrc_a, 1);

    // Branch in the shadow of a taken branch is already a bubble.
    nop(4);
    zero_m = 1'b1;
    opcode = BEQ;
    step();
    chk("shadow first pcsrc e1", pcsrc_a, 0);
    step();
    chk("shadow first pcsrc e2", pcsrc_a, 1);
    opcode = NOP;
    step();
    chk("shadow second pcsrc", pcsrc_a, 0);
    zero_m = 1'b0;

    // Reset mid-flight drops everything; no write enable on that edge or the next.
    nop(4);
    opcode = RT;
    funct  = 6'b100000;
    step();
    opcode = SW;
    step();
    opcode = RT;
    step();
    reset  = 1'b1;
    opcode = SW;
    step();
    chk("midrst memwrite_MEM", mw_a, 0);
    chk("midrst regwrite_MEM", rwm_a, 0);
    chk("midrst regwrite_WB", rwwb_a, 0);
    chk("midrst valid_WB", vwb_a, 0);
    reset = 1'b0;
    step();
    chk("midrst+1 memwrite_MEM", mw_a, 0);
    chk("midrst+1 regwrite_MEM", rwm_a, 0);
    chk("midrst+1 regwrite_WB", rwwb_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
